// File: rtl/riscv_rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// XLEN defaults to 32 and is overridable via the top-level parameter.
package riscv_rf_wb_arbiter_pkg;

    localparam int RF_XLEN = 32;

    localparam int REG_ADDR_W       = 5;
    localparam int NUM_REGS         = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Busy scoreboard for outstanding long-latency destinations plus the
// decode hazard compare. x0 is never marked busy; set beats clear.
module riscv_rf_scoreboard
    import riscv_rf_wb_arbiter_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_set_valid,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_valid,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [NUM_REGS-1:0]   o_busy,
    output logic                  o_hazard_stall
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Next busy vector: clear first so a same-cycle set of the same reg wins.
    always_comb begin
        busy_d = busy_q;
        if (i_clr_valid)
            busy_d[i_clr_addr] = 1'b0;
        if (i_set_valid && (i_set_addr != '0))
            busy_d[i_set_addr] = 1'b1;
    end

    // Busy vector register; reset drops every outstanding destination.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    // Stall decode while a non-zero source is still owned by the long unit.
    always_comb begin
        o_hazard_stall = (busy_q[i_rs1_addr] && (i_rs1_addr != '0)) ||
                         (busy_q[i_rs2_addr] && (i_rs2_addr != '0));
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Arbitrates the single regfile write port between the in-order
// writeback (port A, high priority) and the long-latency unit (port B).
// Optional macro RF_WB_STARVE_EN adds a starvation guard that forces
// B through after STARVE_LIMIT consecutive losses; without it the
// arbiter is strict priority.
module riscv_rf_wb_arbiter
    import riscv_rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = RF_XLEN,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [REG_ADDR_W-1:0] i_a_addr,
    input  logic [XLEN-1:0]       i_a_data,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    input  logic [REG_ADDR_W-1:0] i_b_addr,
    input  logic [XLEN-1:0]       i_b_data,
    input  logic                  i_sb_set_valid,
    input  logic [REG_ADDR_W-1:0] i_sb_set_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic                  o_hazard_stall,
    output logic [NUM_REGS-1:0]   o_sb_busy,
    output logic                  o_rf_rd_wen,
    output logic [REG_ADDR_W-1:0] o_rf_rd_addr,
    output logic [XLEN-1:0]       o_rf_rd_data
);

    logic a_grant, b_grant;

`ifdef RF_WB_STARVE_EN
    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
    logic                    force_b;

    // Grant with starvation guard: a saturated counter hands the port to B.
    always_comb begin
        force_b   = (cnt_q == STARVE_CNT_W'(STARVE_LIMIT)) && i_b_valid;
        o_a_ready = !force_b;
        o_b_ready = force_b || !i_a_valid;
        a_grant   = i_a_valid && o_a_ready;
        b_grant   = i_b_valid && o_b_ready;
        cnt_d     = cnt_q;
        if (!i_b_valid || b_grant)
            cnt_d = '0;
        else if (a_grant && (cnt_q != STARVE_CNT_W'(STARVE_LIMIT)))
            cnt_d = cnt_q + 1'b1;
    end

    // Count consecutive cycles B waits behind A.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    // Strict priority: A always wins, B only fills idle slots.
    always_comb begin
        o_a_ready = 1'b1;
        o_b_ready = !i_a_valid;
        a_grant   = i_a_valid;
        b_grant   = i_b_valid && !i_a_valid;
    end

    // The limit has no meaning without the guard.
    wire unused_starve_limit = |STARVE_LIMIT;
`endif

    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;

    // Select the granted write; x0 writes are accepted but never enabled.
    always_comb begin
        wen_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (a_grant) begin
            wen_d  = (i_a_addr != '0);
            addr_d = i_a_addr;
            data_d = i_a_data;
        end else if (b_grant) begin
            wen_d  = (i_b_addr != '0);
            addr_d = i_b_addr;
            data_d = i_b_data;
        end
    end

    // Registered write stage driving the regfile port directly.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign o_rf_rd_wen  = wen_q;
    assign o_rf_rd_addr = addr_q;
    assign o_rf_rd_data = data_q;

    // A B grant retires its destination on the same edge the write is captured.
    riscv_rf_scoreboard u_sb (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_set_valid    (i_sb_set_valid),
        .i_set_addr     (i_sb_set_addr),
        .i_clr_valid    (b_grant),
        .i_clr_addr     (i_b_addr),
        .i_rs1_addr     (i_rs1_addr),
        .i_rs2_addr     (i_rs2_addr),
        .o_busy         (o_sb_busy),
        .o_hazard_stall (o_hazard_stall)
    );

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Directed bench for riscv_rf_wb_arbiter. Works with or without
// RF_WB_STARVE_EN; starvation expectations follow the macro.
module tb_riscv_rf_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_a_valid, i_b_valid, i_sb_set_valid;
    logic        o_a_ready, o_b_ready, o_hazard_stall, o_rf_rd_wen;
    logic [4:0]  i_a_addr, i_b_addr, i_sb_set_addr, i_rs1_addr, i_rs2_addr, o_rf_rd_addr;
    logic [31:0] i_a_data, i_b_data, o_sb_busy, o_rf_rd_data;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    riscv_rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
        .i_sb_set_valid(i_sb_set_valid), .i_sb_set_addr(i_sb_set_addr),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_hazard_stall(o_hazard_stall), .o_sb_busy(o_sb_busy),
        .o_rf_rd_wen(o_rf_rd_wen), .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd_data(o_rf_rd_data)
    );

    // Upstream must never re-mark a destination that is already busy.
    always @(posedge i_clk) begin
        if (i_rstn && i_sb_set_valid && i_sb_set_addr != 5'd0)
            assert (!o_sb_busy[i_sb_set_addr]) else $error("double set of busy x%0d", i_sb_set_addr);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_a_valid = 0; i_a_addr = 0; i_a_data = 0;
        i_b_valid = 0; i_b_addr = 0; i_b_data = 0;
        i_sb_set_valid = 0; i_sb_set_addr = 0;
        i_rs1_addr = 0; i_rs2_addr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rstn = 0;
        #12;
        tests++; if (o_rf_rd_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %0b exp 0", o_rf_rd_wen); end
        tests++; if (o_rf_rd_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d exp 0", o_rf_rd_addr); end
        tests++; if (o_rf_rd_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h exp 0", o_rf_rd_data); end
        tests++; if (o_sb_busy !== 32'd0) begin fails++; $display("FAIL reset_busy got %h exp 0", o_sb_busy); end
        tests++; if (o_hazard_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b exp 0", o_hazard_stall); end
        @(negedge i_clk);
        i_rstn = 1;
        step();
    endtask

    task automatic test_a_only();
        i_a_valid = 1; i_a_addr = 5; i_a_data = 32'h1234_5678;
        #1;
        tests++; if (o_a_ready !== 1'b1) begin fails++; $display("FAIL a_only_ready got %0b exp 1", o_a_ready); end
        step();
        tests++; if (o_rf_rd_wen !== 1'b1) begin fails++; $display("FAIL a_only_wen got %0b exp 1", o_rf_rd_wen); end
        tests++; if (o_rf_rd_addr !== 5'd5) begin fails++; $display("FAIL a_only_addr got %0d exp 5", o_rf_rd_addr); end
        tests++; if (o_rf_rd_data !== 32'h1234_5678) begin fails++; $display("FAIL a_only_data got %h exp 12345678", o_rf_rd_data); end
        tests++; if (o_a_ready !== 1'b1) begin fails++; $display("FAIL a_only_ready2 got %0b exp 1", o_a_ready); end
        i_a_valid = 0; i_a_addr = 0; i_a_data = 0;
        step();
        tests++; if (o_rf_rd_wen !== 1'b0) begin fails++; $display("FAIL idle_wen got %0b exp 0", o_rf_rd_wen); end
        tests++; if (o_rf_rd_addr !== 5'd5 || o_rf_rd_data !== 32'h1234_5678) begin
            fails++; $display("FAIL idle_hold got x%0d=%h exp x5=12345678", o_rf_rd_addr, o_rf_rd_data); end
    endtask

    task automatic test_starvation();
        logic exp_a, exp_b;
        i_a_valid = 1; i_a_addr = 1;
        i_b_valid = 1; i_b_addr = 2; i_b_data = 32'h0000_00BB;
        for (int c = 0; c < 6; c++) begin
            i_a_data = 32'hA0 + c;
`ifdef RF_WB_STARVE_EN
            exp_b = (c == 4);
`else
            exp_b = 1'b0;
`endif
            exp_a = !exp_b;
            #1;
            tests++; if (o_a_ready !== exp_a || o_b_ready !== exp_b) begin
                fails++; $display("FAIL starve_ready c%0d got a=%0b b=%0b exp a=%0b b=%0b", c, o_a_ready, o_b_ready, exp_a, exp_b); end
            step();
            tests++; if (o_rf_rd_addr !== (exp_b ? 5'd2 : 5'd1) || o_rf_rd_data !== (exp_b ? 32'hBB : 32'hA0 + c)) begin
                fails++; $display("FAIL starve_write c%0d got x%0d=%h exp x%0d", c, o_rf_rd_addr, o_rf_rd_data, exp_b ? 2 : 1); end
        end
        i_a_valid = 0;
        #1;
        tests++; if (o_b_ready !== 1'b1) begin fails++; $display("FAIL b_idle_ready got %0b exp 1", o_b_ready); end
        step();
        tests++; if (o_rf_rd_wen !== 1'b1 || o_rf_rd_addr !== 5'd2 || o_rf_rd_data !== 32'hBB) begin
            fails++; $display("FAIL b_idle_write got wen=%0b x%0d=%h exp wen=1 x2=bb", o_rf_rd_wen, o_rf_rd_addr, o_rf_rd_data); end
        idle_inputs();
        step();
    endtask

    task automatic test_hazard();
        i_sb_set_valid = 1; i_sb_set_addr = 7;
        step();
        i_sb_set_valid = 0; i_sb_set_addr = 0;
        i_rs1_addr = 7;
        #1;
        tests++; if (o_sb_busy !== 32'h0000_0080) begin fails++; $display("FAIL hz_busy_set got %h exp 00000080", o_sb_busy); end
        tests++; if (o_hazard_stall !== 1'b1) begin fails++; $display("FAIL hz_stall got %0b exp 1", o_hazard_stall); end
        step(); step();
        tests++; if (o_hazard_stall !== 1'b1) begin fails++; $display("FAIL hz_stall_hold got %0b exp 1", o_hazard_stall); end
        i_rs1_addr = 0; i_rs2_addr = 7;
        #1;
        tests++; if (o_hazard_stall !== 1'b1) begin fails++; $display("FAIL hz_stall_rs2 got %0b exp 1", o_hazard_stall); end
        i_b_valid = 1; i_b_addr = 7; i_b_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (o_b_ready !== 1'b1 || o_hazard_stall !== 1'b1) begin
            fails++; $display("FAIL hz_pre_grant got ready=%0b stall=%0b exp 1 1", o_b_ready, o_hazard_stall); end
        step();
        i_b_valid = 0;
        #1;
        tests++; if (o_sb_busy[7] !== 1'b0 || o_hazard_stall !== 1'b0) begin
            fails++; $display("FAIL hz_cleared got busy7=%0b stall=%0b exp 0 0", o_sb_busy[7], o_hazard_stall); end
        tests++; if (o_rf_rd_wen !== 1'b1 || o_rf_rd_addr !== 5'd7 || o_rf_rd_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL hz_write got wen=%0b x%0d=%h exp wen=1 x7=deadbeef", o_rf_rd_wen, o_rf_rd_addr, o_rf_rd_data); end
        idle_inputs();
        step();
    endtask

    task automatic test_x0();
        i_a_valid = 1; i_a_addr = 0; i_a_data = 32'hFFFF_FFFF;
        #1;
        tests++; if (o_a_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got %0b exp 1", o_a_ready); end
        step();
        tests++; if (o_rf_rd_wen !== 1'b0) begin fails++; $display("FAIL x0_wen got %0b exp 0", o_rf_rd_wen); end
        i_a_valid = 0;
        i_sb_set_valid = 1; i_sb_set_addr = 0;
        step();
        i_sb_set_valid = 0;
        i_rs1_addr = 0; i_rs2_addr = 0;
        #1;
        tests++; if (o_sb_busy !== 32'd0) begin fails++; $display("FAIL x0_busy got %h exp 0", o_sb_busy); end
        tests++; if (o_hazard_stall !== 1'b0) begin fails++; $display("FAIL x0_stall got %0b exp 0", o_hazard_stall); end
        idle_inputs();
        step();
    endtask

    task automatic test_set_clear_same();
        i_sb_set_valid = 1; i_sb_set_addr = 9;
        i_b_valid = 1; i_b_addr = 9; i_b_data = 32'h99;
        step();
        i_sb_set_valid = 0; i_b_valid = 0;
        #1;
        tests++; if (o_sb_busy !== 32'h0000_0200) begin fails++; $display("FAIL setclr_busy got %h exp 00000200", o_sb_busy); end
        tests++; if (o_rf_rd_wen !== 1'b1 || o_rf_rd_addr !== 5'd9) begin
            fails++; $display("FAIL setclr_write got wen=%0b x%0d exp wen=1 x9", o_rf_rd_wen, o_rf_rd_addr); end
        i_b_valid = 1; i_b_addr = 9; i_b_data = 32'h999;
        step();
        i_b_valid = 0;
        #1;
        tests++; if (o_sb_busy !== 32'd0) begin fails++; $display("FAIL setclr_later got %h exp 0", o_sb_busy); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        i_sb_set_valid = 1; i_sb_set_addr = 3;
        i_a_valid = 1; i_a_addr = 4; i_a_data = 32'h55;
        step();
        i_sb_set_valid = 0;
        i_a_addr = 6; i_a_data = 32'h66;
        i_rs1_addr = 3;
        #1;
        tests++; if (o_rf_rd_wen !== 1'b1 || o_sb_busy[3] !== 1'b1 || o_hazard_stall !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre got wen=%0b busy3=%0b stall=%0b exp 1 1 1", o_rf_rd_wen, o_sb_busy[3], o_hazard_stall); end
        i_rstn = 0;
        #1;
        tests++; if (o_rf_rd_wen !== 1'b0 || o_rf_rd_addr !== 5'd0 || o_rf_rd_data !== 32'd0) begin
            fails++; $display("FAIL rstmid_out got wen=%0b x%0d=%h exp all 0", o_rf_rd_wen, o_rf_rd_addr, o_rf_rd_data); end
        tests++; if (o_sb_busy !== 32'd0 || o_hazard_stall !== 1'b0) begin
            fails++; $display("FAIL rstmid_busy got %h stall=%0b exp 0 0", o_sb_busy, o_hazard_stall); end
        idle_inputs();
        @(negedge i_clk);
        i_rstn = 1;
        step();
        tests++; if (o_rf_rd_wen !== 1'b0 || o_rf_rd_data !== 32'd0) begin
            fails++; $display("FAIL rstmid_after got wen=%0b data=%h exp 0 0", o_rf_rd_wen, o_rf_rd_data); end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_starvation();
        test_hazard();
        test_x0();
        test_set_clear_same();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_rf_wb_arbiter.md
Name: riscv_rf_wb_arbiter

Overview:
- Shares the single write port of the RV32I register file between two writeback requesters.
  - Port A: the in-order pipeline writeback. High priority.
  - Port B: the long-latency unit (load / mul-div). Low priority.
- Keeps a 32-entry busy scoreboard for outstanding long-latency destinations. Raises a hazard stall for decode when a source register is busy.
- Sits between the writeback stage and the register file. Its registered outputs drive the regfile write port directly.

Parameters:
- XLEN, 32, data width; equals the core `XLEN.
- STARVE_LIMIT, 4, consecutive cycles port B may wait while A wins before B is forced through. Range 1..15.

Ports:
- i_clk  input  1  core clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_a_valid  input  1  port A write request.
- o_a_ready  output  1  port A accepted this cycle.
- i_a_addr  input  5  port A destination register.
- i_a_data  input  XLEN  port A write data.
- i_b_valid  input  1  port B write request.
- o_b_ready  output  1  port B accepted this cycle.
- i_b_addr  input  5  port B destination register.
- i_b_data  input  XLEN  port B write data.
- i_sb_set_valid  input  1  long-latency op issued; mark its destination busy.
- i_sb_set_addr  input  5  destination of the issued op.
- i_rs1_addr  input  5  decode source 1.
- i_rs2_addr  input  5  decode source 2.
- o_hazard_stall  output  1  decode must stall.
- o_sb_busy  output  32  scoreboard vector; bit n means xn is busy.
- o_rf_rd_wen  output  1  to regfile write enable.
- o_rf_rd_addr  output  5  to regfile write address.
- o_rf_rd_data  output  XLEN  to regfile write data.

Behaviour:
- Reset (async, i_rstn=0):
  - o_rf_rd_wen=0, o_rf_rd_addr=0, o_rf_rd_data=0.
  - o_sb_busy=0.
  - Starvation counter=0.
- Reset mid-operation drops any in-flight write and clears all busy bits.
- Handshake:
  - Ready signals are combinational from valids and the counter. They are never dependent on the same-cycle data.
  - A transfer occurs when valid&&ready at posedge.
  - A requester holds addr/data stable while valid&&!ready.
- Grant rule (starvation guard enabled):
  - force_b = (cnt == STARVE_LIMIT) && i_b_valid.
  - o_a_ready = !force_b.
  - o_b_ready = force_b || !i_a_valid.
  - At most one grant per cycle.
- Counter:
  - Increments when i_b_valid && i_a_valid && A granted.
  - Saturates at STARVE_LIMIT.
  - Clears on a B grant or when !i_b_valid.
- Write stage: registered, 1-cycle latency.
  - The granted addr/data are captured at posedge.
  - o_rf_rd_wen = granted && addr!=0.
  - Writes to x0 are accepted (ready high) and dropped.
  - With no grant, wen=0 and addr/data hold their last values.
- Scoreboard:
  - Set: i_sb_set_valid && i_sb_set_addr!=0 sets the bit at posedge.
  - Clear: a B grant clears bit i_b_addr at the same posedge that the write stage captures.
  - Set and clear of the same register in one cycle: set wins.
  - Setting an already-busy register is an upstream protocol error; the bit stays 1. The bench asserts this never happens.
  - A grants never touch the scoreboard.
- Hazard: o_hazard_stall = (o_sb_busy[rs1] && rs1!=0) || (o_sb_busy[rs2] && rs2!=0).
  - Combinational from the registered busy vector.
  - No stall in the cycle after the clearing edge.
- Timing: the regfile writes on negedge, so the write captured at posedge N is readable in the second half of cycle N. The cleared busy bit and the visible data coincide.

Optional Feature:
- Macro: RF_WB_STARVE_EN.
- Defined: the starvation counter and force_b exist as above.
- Undefined: strict priority. o_a_ready=1 always; o_b_ready=!i_a_valid. No counter flops; STARVE_LIMIT is ignored.

Decomposition:
- Shared package/config include holds:
  - XLEN (existing `XLEN).
  - REG_ADDR_W=5.
  - NUM_REGS=32.
  - Default STARVE_LIMIT constant.
- One natural sub-module: riscv_rf_scoreboard. It holds the busy vector, set/clear priority, and the hazard compare.
- Arbitration and the write stage stay in the top module.

Test Plan:
- Reset, then A-only writes x5=0x1234_5678 → next posedge: wen=1, addr=5, data=0x12345678; o_a_ready stays 1.
- A and B both valid continuously, STARVE_LIMIT=4, STARVE_EN defined → A wins 4 cycles, B granted on the 5th (o_a_ready=0 that cycle), then the counter clears. With the macro undefined, B is never granted while A is valid.
- Set busy x7 via i_sb_set, then decode rs1=7 → o_hazard_stall=1 until B writes x7=0xDEAD_BEEF. The bit clears at the grant edge; the stall drops in the next cycle; the regfile reads 0xDEADBEEF.
- Write x0 from A with data 0xFFFF_FFFF → accepted; wen=0. Set-busy on x0 → o_sb_busy[0] stays 0; rs1=0 never stalls.
- Same-cycle set x9 and B-clear x9 → o_sb_busy[9]=1 afterwards.
- Assert i_rstn low mid-stream with x3 busy and a write pending → outputs are immediately 0, o_sb_busy=0, and no write follows reset release.
